// File: rtl/alpha_pkg.sv
// Shared types and arithmetic helpers for the global-phase alpha engine.
// Helpers work on wide signed values so they serve any amplitude width up to 63 bits.
package alpha_pkg;

  typedef enum logic [2:0] {
    GATE_H    = 3'd0,
    GATE_S    = 3'd1,
    GATE_CNOT = 3'd2,
    GATE_Z    = 3'd3,
    GATE_X    = 3'd4,
    GATE_SDG  = 3'd5
  } gate_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_CHK,
    ST_SCALE,
    ST_DONE
  } state_e;

  localparam int LAST_GATE = 5;

  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // round(0.70710678 * 2^frac) in pure integer arithmetic
  function automatic longint inv_sqrt2(input int frac);
    return (longint'(70710678) * (longint'(1) << frac) + longint'(50000000))
           / longint'(100000000);
  endfunction

  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] v, input int w);
    logic signed [63:0] lo;
    lo = -(64'sd1 <<< (w - 1));
    if (v == lo) return (64'sd1 <<< (w - 1)) - 64'sd1;
    return -v;
  endfunction

  function automatic logic signed [63:0] round_shift_sat(input logic signed [127:0] v,
                                                         input int frac, input int w);
    logic signed [127:0] r;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    r  = (v + (128'sd1 <<< (frac - 1))) >>> frac;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return 64'(r);
  endfunction

endpackage

// File: rtl/cplx_scale_sat.sv
// Registered complex-by-1/sqrt2 scaler with round-half-up and saturation to AMP_W bits.
module cplx_scale_sat
  import alpha_pkg::*;
#(
  parameter int AMP_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_new,
  input  logic                    en_i,
  input  logic signed [AMP_W:0]   inR_i,
  input  logic signed [AMP_W:0]   inI_i,
  output logic signed [AMP_W-1:0] outR_o,
  output logic signed [AMP_W-1:0] outI_o
);

  // Product width covers (AMP_W+1)-bit input, FRAC_W+1-bit constant and the rounding carry
  localparam int MW = AMP_W + FRAC_W + 3;
  localparam logic signed [MW-1:0] K = MW'(inv_sqrt2(FRAC_W));

  logic signed [MW-1:0]    prodR, prodI;
  logic signed [AMP_W-1:0] satR, satI;

  function automatic logic signed [AMP_W-1:0] roundSat(input logic signed [MW-1:0] p);
    logic signed [127:0] wide;
    wide = 128'(p);
    return AMP_W'(round_shift_sat(wide, FRAC_W, AMP_W));
  endfunction

  always_comb begin
    prodR = MW'(inR_i) * K;
    prodI = MW'(inI_i) * K;
    satR  = roundSat(prodR);
    satI  = roundSat(prodI);
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      outR_o <= '0;
      outI_o <= '0;
    end else if (en_i) begin
      outR_o <= satR;
      outI_o <= satI;
    end
  end

endmodule

// File: rtl/alpha_engine.sv
// Per-gate global-phase coefficient (alpha) and basis-index update for the stabilizer emulator.
// Hadamard takes CALC->CHK->SCALE, every other gate (and any error) goes straight to DONE.
module alpha_engine
  import alpha_pkg::*;
#(
  parameter int NUM_QUBIT = 4,
  parameter int AMP_W     = 32,
  parameter int FRAC_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_new,
  input  logic                          start,
  output logic                          ready,
  input  logic [2:0]                    gate_type,
  input  logic [NUM_QUBIT-1:0]          basis_index,
  input  logic [pos_w(NUM_QUBIT)-1:0]   qubit_pos,
  input  logic [pos_w(NUM_QUBIT)-1:0]   ctrl_pos,
  input  logic signed [AMP_W-1:0]       amplitude_r,
  input  logic signed [AMP_W-1:0]       amplitude_i,
  input  logic signed [AMP_W-1:0]       amplitude2_r,
  input  logic signed [AMP_W-1:0]       amplitude2_i,
  output logic signed [AMP_W-1:0]       alpha_r,
  output logic signed [AMP_W-1:0]       alpha_i,
  output logic [NUM_QUBIT-1:0]          basis_index_out,
  output logic                          initial_alpha_zero,
  output logic                          gate_err,
  output logic                          done
);

  localparam int PW = pos_w(NUM_QUBIT);

  state_e                  state_q, state_d;
  gate_e                   gate_q, gate_d;
  logic [NUM_QUBIT-1:0]    basis_q, basis_d;
  logic [NUM_QUBIT-1:0]    basisOut_q, basisOut_d;
  logic [PW-1:0]           qpos_q, qpos_d, cpos_q, cpos_d;
  logic signed [AMP_W-1:0] ar_q, ar_d, ai_q, ai_d;
  logic signed [AMP_W-1:0] a2r_q, a2r_d, a2i_q, a2i_d;
  logic signed [AMP_W:0]   alphaR_q, alphaR_d, alphaI_q, alphaI_d;
  logic                    iaz_q, iaz_d;
  logic                    err_q, err_d;
  logic                    scaled_q, scaled_d;

  logic                    reqErr;
  logic                    tBit;
  logic [NUM_QUBIT-1:0]    flipMask;
  logic signed [AMP_W-1:0] scR, scI;

  function automatic logic signed [AMP_W:0] ext1(input logic signed [AMP_W-1:0] v);
    return {v[AMP_W-1], v};
  endfunction

  function automatic logic signed [AMP_W-1:0] negA(input logic signed [AMP_W-1:0] v);
    logic signed [63:0] wide;
    wide = 64'(v);
    return AMP_W'(sat_neg(wide, AMP_W));
  endfunction

  // Request checks are evaluated on the live inputs so the verdict is latched with them
  assign reqErr = (int'(gate_type) > LAST_GATE)
               || (int'(qubit_pos) >= NUM_QUBIT)
               || (int'(ctrl_pos) >= NUM_QUBIT)
               || ((gate_type == GATE_CNOT) && (ctrl_pos == qubit_pos));

  assign tBit     = basis_q[qpos_q];
  assign flipMask = NUM_QUBIT'(1) << qpos_q;

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    basis_d    = basis_q;
    basisOut_d = basisOut_q;
    qpos_d     = qpos_q;
    cpos_d     = cpos_q;
    ar_d       = ar_q;
    ai_d       = ai_q;
    a2r_d      = a2r_q;
    a2i_d      = a2i_q;
    alphaR_d   = alphaR_q;
    alphaI_d   = alphaI_q;
    iaz_d      = iaz_q;
    err_d      = err_q;
    scaled_d   = scaled_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gate_d   = gate_e'(gate_type);
          basis_d  = basis_index;
          qpos_d   = qubit_pos;
          cpos_d   = ctrl_pos;
          ar_d     = amplitude_r;
          ai_d     = amplitude_i;
          a2r_d    = amplitude2_r;
          a2i_d    = amplitude2_i;
          err_d    = reqErr;
          iaz_d    = 1'b0;
          scaled_d = 1'b0;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        alphaR_d   = ext1(ar_q);
        alphaI_d   = ext1(ai_q);
        basisOut_d = basis_q;
        state_d    = ST_DONE;
        if (!err_q) begin
          case (gate_q)
            GATE_H: begin
              state_d = ST_CHK;
              if (tBit) begin
                alphaR_d = ext1(a2r_q) - ext1(ar_q);
                alphaI_d = ext1(a2i_q) - ext1(ai_q);
              end else begin
                alphaR_d = ext1(ar_q) + ext1(a2r_q);
                alphaI_d = ext1(ai_q) + ext1(a2i_q);
              end
            end
            GATE_S: begin
              if (tBit) begin
                alphaR_d = ext1(negA(ai_q));
                alphaI_d = ext1(ar_q);
              end
            end
            GATE_SDG: begin
              if (tBit) begin
                alphaR_d = ext1(ai_q);
                alphaI_d = ext1(negA(ar_q));
              end
            end
            GATE_Z: begin
              if (tBit) begin
                alphaR_d = ext1(negA(ar_q));
                alphaI_d = ext1(negA(ai_q));
              end
            end
            GATE_X:    basisOut_d = basis_q ^ flipMask;
            GATE_CNOT: if (basis_q[cpos_q]) basisOut_d = basis_q ^ flipMask;
            default: ;
          endcase
        end
      end

      // A zero first attempt means the partner basis carries the phase: use the other sign
      ST_CHK: begin
        state_d = ST_SCALE;
        if ((alphaR_q == '0) && (alphaI_q == '0)) begin
          iaz_d      = 1'b1;
          basisOut_d = basis_q ^ flipMask;
          if (tBit) begin
            alphaR_d = ext1(ar_q) + ext1(a2r_q);
            alphaI_d = ext1(ai_q) + ext1(a2i_q);
          end else begin
            alphaR_d = ext1(ar_q) - ext1(a2r_q);
            alphaI_d = ext1(ai_q) - ext1(a2i_q);
          end
        end
      end

      ST_SCALE: begin
        scaled_d = 1'b1;
        state_d  = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      state_q    <= ST_IDLE;
      gate_q     <= GATE_H;
      basis_q    <= '0;
      basisOut_q <= '0;
      qpos_q     <= '0;
      cpos_q     <= '0;
      ar_q       <= '0;
      ai_q       <= '0;
      a2r_q      <= '0;
      a2i_q      <= '0;
      alphaR_q   <= '0;
      alphaI_q   <= '0;
      iaz_q      <= 1'b0;
      err_q      <= 1'b0;
      scaled_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      basis_q    <= basis_d;
      basisOut_q <= basisOut_d;
      qpos_q     <= qpos_d;
      cpos_q     <= cpos_d;
      ar_q       <= ar_d;
      ai_q       <= ai_d;
      a2r_q      <= a2r_d;
      a2i_q      <= a2i_d;
      alphaR_q   <= alphaR_d;
      alphaI_q   <= alphaI_d;
      iaz_q      <= iaz_d;
      err_q      <= err_d;
      scaled_q   <= scaled_d;
    end
  end

  cplx_scale_sat #(
    .AMP_W (AMP_W),
    .FRAC_W(FRAC_W)
  ) u_scale (
    .clk    (clk),
    .rst_new(rst_new),
    .en_i   (state_q == ST_SCALE),
    .inR_i  (alphaR_q),
    .inI_i  (alphaI_q),
    .outR_o (scR),
    .outI_o (scI)
  );

  // Hadamard results live in the scaler register; everything else in alpha*_q
  assign alpha_r            = scaled_q ? scR : AMP_W'(alphaR_q);
  assign alpha_i            = scaled_q ? scI : AMP_W'(alphaI_q);
  assign basis_index_out    = basisOut_q;
  assign initial_alpha_zero = iaz_q;
  assign gate_err           = err_q;
  assign ready              = (state_q == ST_IDLE);
  assign done               = (state_q == ST_DONE);

endmodule

// File: tb/tb_alpha_engine.sv
// Self-checking bench for alpha_engine: directed vector table, handshake/reset sequences,
// and randomized requests checked against an arithmetic reference model.
module tb_alpha_engine;

  localparam int NUM_QUBIT = 4;
  localparam int AMP_W     = 32;
  localparam int FRAC_W    = 16;
  localparam longint AMAX  = (64'sd1 <<< (AMP_W - 1)) - 64'sd1;
  localparam longint AMIN  = -(64'sd1 <<< (AMP_W - 1));
  localparam longint KREF  = longint'($rtoi(0.70710678 * (2.0 ** FRAC_W) + 0.5));

  typedef struct {
    int     gate;
    int     basis;
    int     qpos;
    int     cpos;
    longint ar, ai, a2r, a2i;
    longint expAr, expAi;
    int     expBasis, expIaz, expErr, expLat;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst_new;
  logic                    start;
  logic                    ready;
  logic [2:0]              gate_type;
  logic [NUM_QUBIT-1:0]    basis_index;
  logic [1:0]              qubit_pos, ctrl_pos;
  logic signed [AMP_W-1:0] amplitude_r, amplitude_i, amplitude2_r, amplitude2_i;
  logic signed [AMP_W-1:0] alpha_r, alpha_i;
  logic [NUM_QUBIT-1:0]    basis_index_out;
  logic                    initial_alpha_zero, gate_err, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alpha_engine #(
    .NUM_QUBIT(NUM_QUBIT),
    .AMP_W    (AMP_W),
    .FRAC_W   (FRAC_W)
  ) dut (
    .clk               (clk),
    .rst_new           (rst_new),
    .start             (start),
    .ready             (ready),
    .gate_type         (gate_type),
    .basis_index       (basis_index),
    .qubit_pos         (qubit_pos),
    .ctrl_pos          (ctrl_pos),
    .amplitude_r       (amplitude_r),
    .amplitude_i       (amplitude_i),
    .amplitude2_r      (amplitude2_r),
    .amplitude2_i      (amplitude2_i),
    .alpha_r           (alpha_r),
    .alpha_i           (alpha_i),
    .basis_index_out   (basis_index_out),
    .initial_alpha_zero(initial_alpha_zero),
    .gate_err          (gate_err),
    .done              (done)
  );

  function automatic longint negM(input longint x);
    return (x == AMIN) ? AMAX : -x;
  endfunction

  function automatic longint scaleM(input longint x);
    longint p;
    p = (x * KREF + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
    if (p > AMAX) return AMAX;
    if (p < AMIN) return AMIN;
    return p;
  endfunction

  // Reference: fills the expected fields of v from the gate rules
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     t;
    longint sr, si;
    r = v;
    t = (v.basis >> v.qpos) & 1;
    r.expAr = v.ar;  r.expAi = v.ai;  r.expBasis = v.basis;
    r.expIaz = 0;    r.expErr = 0;    r.expLat = 2;
    if (v.gate > 5 || v.qpos >= NUM_QUBIT || v.cpos >= NUM_QUBIT || (v.gate == 2 && v.cpos == v.qpos)) begin
      r.expErr = 1;
      return r;
    end
    case (v.gate)
      0: begin
        r.expLat = 4;
        sr = t ? v.a2r - v.ar : v.ar + v.a2r;
        si = t ? v.a2i - v.ai : v.ai + v.a2i;
        if (sr == 0 && si == 0) begin
          sr = t ? v.ar + v.a2r : v.ar - v.a2r;
          si = t ? v.ai + v.a2i : v.ai - v.a2i;
          r.expIaz = 1;
          r.expBasis = v.basis ^ (1 << v.qpos);
        end
        r.expAr = scaleM(sr);
        r.expAi = scaleM(si);
      end
      1: if (t == 1) begin r.expAr = negM(v.ai); r.expAi = v.ar; end
      5: if (t == 1) begin r.expAr = v.ai; r.expAi = negM(v.ar); end
      3: if (t == 1) begin r.expAr = negM(v.ar); r.expAi = negM(v.ai); end
      4: r.expBasis = v.basis ^ (1 << v.qpos);
      2: r.expBasis = v.basis ^ (((v.basis >> v.cpos) & 1) << v.qpos);
      default: ;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    gate_type    = 3'(v.gate);
    basis_index  = 4'(v.basis);
    qubit_pos    = 2'(v.qpos);
    ctrl_pos     = 2'(v.cpos);
    amplitude_r  = 32'(v.ar);
    amplitude_i  = 32'(v.ai);
    amplitude2_r = 32'(v.a2r);
    amplitude2_i = 32'(v.a2i);
  endtask

  // Issues one request and returns the cycle (1 = first after accept) in which done rose
  task automatic applyStimulus(input vec_t v, output int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("ready_idle", longint'(ready), 1);
    driveInputs(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input vec_t v, input int lat);
    longint heldR;
    checkOutput({tag, " latency"}, lat, v.expLat);
    checkOutput({tag, " alpha_r"}, longint'(alpha_r), v.expAr);
    checkOutput({tag, " alpha_i"}, longint'(alpha_i), v.expAi);
    checkOutput({tag, " basis_out"}, longint'(basis_index_out), v.expBasis);
    checkOutput({tag, " init_zero"}, longint'(initial_alpha_zero), v.expIaz);
    checkOutput({tag, " gate_err"}, longint'(gate_err), v.expErr);
    heldR = longint'(alpha_r);
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, longint'(done), 0);
    checkOutput({tag, " hold_alpha_r"}, longint'(alpha_r), v.expAr);
    if (lat == 0) checkOutput({tag, " hold_seen"}, heldR, v.expAr);
  endtask

  vec_t vecs[13];
  vec_t rv;
  int   lat;
  int   doneSeen;
  logic readyLog[1:9];
  logic doneLog[1:9];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_new = 1'b1;
    start   = 1'b0;
    driveInputs('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    repeat (2) @(negedge clk);
    rst_new = 1'b0;
    @(negedge clk);
    checkOutput("reset ready", longint'(ready), 1);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset alpha_r", longint'(alpha_r), 0);
    checkOutput("reset alpha_i", longint'(alpha_i), 0);
    checkOutput("reset basis_out", longint'(basis_index_out), 0);
    checkOutput("reset gate_err", longint'(gate_err), 0);

    //           gate basis q  c  ar      ai    a2r     a2i  expAr   expAi   eB     iaz err lat
    vecs[0]  = '{0, 4'b0000, 0, 1, 65536, 0, 65536, 0, 92682, 0, 4'b0000, 0, 0, 4};
    vecs[1]  = '{0, 4'b0001, 0, 1, 65536, 0, 65536, 0, 92682, 0, 4'b0000, 1, 0, 4};
    vecs[2]  = '{1, 4'b0001, 0, 1, 100, 200, 0, 0, -200, 100, 4'b0001, 0, 0, 2};
    vecs[3]  = '{5, 4'b0001, 0, 1, 100, 200, 0, 0, 200, -100, 4'b0001, 0, 0, 2};
    vecs[4]  = '{2, 4'b0001, 2, 0, 7, -9, 0, 0, 7, -9, 4'b0101, 0, 0, 2};
    vecs[5]  = '{2, 4'b0001, 2, 2, 7, -9, 0, 0, 7, -9, 4'b0001, 0, 1, 2};
    vecs[6]  = '{3, 4'b0010, 1, 0, AMIN, 5, 0, 0, AMAX, -5, 4'b0010, 0, 0, 2};
    vecs[7]  = '{0, 4'b0000, 3, 0, AMAX, 0, AMAX, 0, AMAX, 0, 4'b0000, 0, 0, 4};
    vecs[8]  = '{4, 4'b1010, 0, 1, 3, 4, 0, 0, 3, 4, 4'b1011, 0, 0, 2};
    vecs[9]  = '{6, 4'b0110, 1, 0, 11, 12, 0, 0, 11, 12, 4'b0110, 0, 1, 2};
    vecs[10] = '{3, 4'b0000, 2, 0, -5, 6, 0, 0, -5, 6, 4'b0000, 0, 0, 2};
    vecs[11] = '{0, 4'b0000, 1, 0, -1, 3, 0, 0, -1, 2, 4'b0000, 0, 0, 4};
    vecs[12] = '{1, 4'b0000, 0, 1, 9, 8, 0, 0, 9, 8, 4'b0000, 0, 0, 2};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], lat);
      checkResult($sformatf("vec%0d", i), vecs[i], lat);
    end

    // start held through an H: the next request must wait until the cycle after done
    @(negedge clk);
    driveInputs(vecs[0]);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      readyLog[c] = ready;
      doneLog[c]  = done;
      if (c == 6) start = 1'b0;
    end
    for (int c = 1; c <= 3; c++) checkOutput($sformatf("held c%0d done", c), longint'(doneLog[c]), 0);
    for (int c = 1; c <= 4; c++) checkOutput($sformatf("held c%0d ready", c), longint'(readyLog[c]), 0);
    checkOutput("held c4 done", longint'(doneLog[4]), 1);
    checkOutput("held c5 ready", longint'(readyLog[5]), 1);
    checkOutput("held c6 ready", longint'(readyLog[6]), 0);
    checkOutput("held c9 done", longint'(doneLog[9]), 1);
    checkOutput("held alpha_r", longint'(alpha_r), 92682);

    // asynchronous reset landing in SCALE
    @(negedge clk);
    driveInputs('{0, 4'b0101, 1, 0, 300, 400, 500, 600, 0, 0, 0, 0, 0, 0});
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_new = 1'b1;
    #1;
    checkOutput("rst_scale ready", longint'(ready), 1);
    checkOutput("rst_scale done", longint'(done), 0);
    checkOutput("rst_scale alpha_r", longint'(alpha_r), 0);
    checkOutput("rst_scale alpha_i", longint'(alpha_i), 0);
    checkOutput("rst_scale basis_out", longint'(basis_index_out), 0);
    @(negedge clk);
    rst_new = 1'b0;
    doneSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("rst_scale no_done", doneSeen, 0);
    checkOutput("rst_scale alpha_after", longint'(alpha_r), 0);

    for (int n = 0; n < 150; n++) begin
      int sel;
      int t;
      rv.gate  = $urandom_range(0, 7);
      rv.basis = $urandom_range(0, 15);
      rv.qpos  = $urandom_range(0, 3);
      rv.cpos  = ($urandom_range(0, 3) == 0) ? rv.qpos : $urandom_range(0, 3);
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        rv.ar  = longint'($urandom_range(0, 2000)) - 1000;
        rv.ai  = longint'($urandom_range(0, 2000)) - 1000;
        rv.a2r = longint'($urandom_range(0, 2000)) - 1000;
        rv.a2i = longint'($urandom_range(0, 2000)) - 1000;
      end else if (sel == 1) begin
        rv.ar  = longint'($signed($urandom()));
        rv.ai  = longint'($signed($urandom()));
        rv.a2r = longint'($signed($urandom()));
        rv.a2i = longint'($signed($urandom()));
      end else begin
        rv.ar  = ($urandom_range(0, 1) == 1) ? AMIN : AMAX;
        rv.ai  = ($urandom_range(0, 1) == 1) ? AMIN : -1;
        rv.a2r = ($urandom_range(0, 1) == 1) ? AMAX : 0;
        rv.a2i = ($urandom_range(0, 1) == 1) ? AMIN : 1;
      end
      if (rv.gate == 0 && $urandom_range(0, 2) == 0) begin
        t = (rv.basis >> rv.qpos) & 1;
        if (rv.ar == AMIN) rv.ar = rv.ar + 1;
        if (rv.ai == AMIN) rv.ai = rv.ai + 1;
        rv.a2r = t ? rv.ar : -rv.ar;
        rv.a2i = t ? rv.ai : -rv.ai;
      end
      rv = model(rv);
      applyStimulus(rv, lat);
      checkResult($sformatf("rand%0d g%0d", n, rv.gate), rv, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
